// File: rtl/branch_pred_table_if.sv
// Branch predictor lookup/update bundle between the IF/ID pipeline stages and
// the prediction table.
//   master: pipeline side (drives lk_pc and the up_* resolution fields)
//   slave : predictor side (returns lk_taken/lk_idx, mispredict and statistics)
interface branch_pred_table_if #(
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned STAT_W = 16
);
    logic [29:0]       lk_pc;
    logic              lk_taken;
    logic [IDX_W-1:0]  lk_idx;
    logic              up_valid;
    logic [IDX_W-1:0]  up_idx;
    logic              up_taken;
    logic              up_pred;
    logic              mispredict;
    logic [STAT_W-1:0] hit_cnt;
    logic [STAT_W-1:0] miss_cnt;

    modport master (
        output lk_pc, up_valid, up_idx, up_taken, up_pred,
        input  lk_taken, lk_idx, mispredict, hit_cnt, miss_cnt
    );

    modport slave (
        input  lk_pc, up_valid, up_idx, up_taken, up_pred,
        output lk_taken, lk_idx, mispredict, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_pred_table.sv
// Table of 2^IDX_W saturating counters for branch direction prediction.
// Indexing is bimodal (MODE=0, PC bits) or gshare (MODE=1, PC XOR history).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   stall      : pipeline stall; freezes table, history and statistics
//   bus.lk_*   : combinational IF-stage lookup (lk_pc -> lk_taken, lk_idx)
//   bus.up_*   : ID-stage resolution; commits once when up_valid & ~stall
//   bus.mispredict : combinational, resolved branch disagreed with prediction
//   bus.hit_cnt/miss_cnt : registered saturating statistics
module branch_pred_table #(
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned CTR_W  = 2,
    parameter int unsigned HIST_W = 4,
    parameter int unsigned MODE   = 0,
    parameter int unsigned STAT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    branch_pred_table_if.slave bus
);
    localparam int unsigned       DEPTH    = 1 << IDX_W;
    localparam int unsigned       GHR_W    = (HIST_W == 0) ? 1 : HIST_W;
    localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [CTR_W-1:0]  table_q [DEPTH];
    logic [GHR_W-1:0]  ghr_q;
    logic [GHR_W-1:0]  ghr_nxt_c;
    logic [IDX_W-1:0]  hist_pad_c;
    logic [IDX_W-1:0]  lk_idx_c;
    logic              commit_c;
    logic              correct_c;
    logic [CTR_W-1:0]  ctr_cur_c;
    logic [CTR_W-1:0]  ctr_nxt_c;
    logic [STAT_W-1:0] hit_q;
    logic [STAT_W-1:0] miss_q;
    logic              unused_c;

    // History contribution to the index and history shift path
    generate
        if (MODE == 1 && HIST_W > 0) begin : g_gshare
            assign hist_pad_c = IDX_W'(ghr_q);
        end else begin : g_bimodal
            assign hist_pad_c = '0;
        end

        if (HIST_W > 1) begin : g_hist_shift
            assign ghr_nxt_c = {ghr_q[GHR_W-2:0], bus.up_taken};
        end else begin : g_hist_bit
            assign ghr_nxt_c = bus.up_taken;
        end
    endgenerate

    // Lookup: no bypass, a same-cycle update is seen from the next cycle on
    assign lk_idx_c     = bus.lk_pc[IDX_W-1:0] ^ hist_pad_c;
    assign bus.lk_idx   = lk_idx_c;
    assign bus.lk_taken = table_q[lk_idx_c][CTR_W-1];

    assign commit_c       = bus.up_valid & ~stall;
    assign correct_c      = (bus.up_pred == bus.up_taken);
    assign bus.mispredict = rst_n & commit_c & ~correct_c;
    assign bus.hit_cnt    = hit_q;
    assign bus.miss_cnt   = miss_q;

    // Upper PC bits never reach the index; history is unread in bimodal mode
    assign unused_c = ^{bus.lk_pc[29:IDX_W], ghr_q};

    // Saturating counter step for the resolved entry
    always_comb begin
        ctr_cur_c = table_q[bus.up_idx];
        ctr_nxt_c = ctr_cur_c;
        if (bus.up_taken) begin
            if (ctr_cur_c != CTR_MAX) begin
                ctr_nxt_c = ctr_cur_c + CTR_W'(1);
            end
        end else begin
            if (ctr_cur_c != '0) begin
                ctr_nxt_c = ctr_cur_c - CTR_W'(1);
            end
        end
    end

    // Counter table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= CTR_INIT;
            end
        end else if (commit_c) begin
            table_q[bus.up_idx] <= ctr_nxt_c;
        end
    end

    // Non-speculative global history, updated only by resolved branches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (commit_c && HIST_W > 0) begin
            ghr_q <= ghr_nxt_c;
        end
    end

    // Hit/miss statistics, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (commit_c) begin
            if (correct_c) begin
                if (hit_q != STAT_MAX) begin
                    hit_q <= hit_q + STAT_W'(1);
                end
            end else begin
                if (miss_q != STAT_MAX) begin
                    miss_q <= miss_q + STAT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_pred_table.sv
module tb_branch_pred_table;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    int unsigned pass_cnt  = 0;
    int unsigned check_cnt = 0;

    branch_pred_table_if #(.IDX_W(6), .STAT_W(16)) if_b ();
    branch_pred_table_if #(.IDX_W(6), .STAT_W(16)) if_g ();
    branch_pred_table_if #(.IDX_W(6), .STAT_W(4))  if_s ();

    branch_pred_table #(.IDX_W(6), .CTR_W(2), .HIST_W(4), .MODE(0), .STAT_W(16)) u_bi (
        .clk(clk), .rst_n(rst_n), .stall(stall), .bus(if_b.slave));
    branch_pred_table #(.IDX_W(6), .CTR_W(2), .HIST_W(4), .MODE(1), .STAT_W(16)) u_gs (
        .clk(clk), .rst_n(rst_n), .stall(stall), .bus(if_g.slave));
    branch_pred_table #(.IDX_W(6), .CTR_W(2), .HIST_W(4), .MODE(0), .STAT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .bus(if_s.slave));

    always #5 clk = ~clk;

    task automatic idle_all();
        stall         = 1'b0;
        if_b.up_valid = 1'b0; if_b.up_idx = '0; if_b.up_taken = 1'b0; if_b.up_pred = 1'b0;
        if_g.up_valid = 1'b0; if_g.up_idx = '0; if_g.up_taken = 1'b0; if_g.up_pred = 1'b0;
        if_s.up_valid = 1'b0; if_s.up_idx = '0; if_s.up_taken = 1'b0; if_s.up_pred = 1'b0;
        if_b.lk_pc = '0; if_g.lk_pc = '0; if_s.lk_pc = '0;
    endtask

    task automatic test_reset();
        idle_all();
        #1;
        check_cnt++;
        if (if_b.mispredict !== 1'b0) $display("FAIL rst_mispredict: got %0b expected 0", if_b.mispredict);
        else pass_cnt++;
        check_cnt++;
        if (if_b.hit_cnt !== 16'd0) $display("FAIL rst_hit: got %0d expected 0", if_b.hit_cnt);
        else pass_cnt++;
        check_cnt++;
        if (if_b.miss_cnt !== 16'd0) $display("FAIL rst_miss: got %0d expected 0", if_b.miss_cnt);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int pc = 0; pc < 64; pc++) begin
            if_b.lk_pc = 30'(pc);
            if_g.lk_pc = 30'(pc);
            #1;
            check_cnt++;
            if (if_b.lk_taken !== 1'b0) $display("FAIL rst_lk_taken[%0d]: got %0b expected 0", pc, if_b.lk_taken);
            else pass_cnt++;
            check_cnt++;
            if (if_g.lk_idx !== 6'(pc)) $display("FAIL rst_gs_idx[%0d]: got %0d expected %0d", pc, if_g.lk_idx, pc);
            else pass_cnt++;
        end
    endtask

    task automatic test_bimodal_sat();
        logic [1:0] exp_ctr [7] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
        logic       tk      [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       exp_mp  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        idle_all();
        if_b.lk_pc = 30'd5;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if_b.up_valid = 1'b1; if_b.up_idx = 6'd5;
            if_b.up_taken = tk[k]; if_b.up_pred = exp_ctr[k][1];
            #1;
            check_cnt++;
            if (if_b.lk_taken !== exp_ctr[k][1])
                $display("FAIL bi_seq_taken[%0d]: got %0b expected %0b", k, if_b.lk_taken, exp_ctr[k][1]);
            else pass_cnt++;
            check_cnt++;
            if (if_b.mispredict !== exp_mp[k])
                $display("FAIL bi_seq_mispredict[%0d]: got %0b expected %0b", k, if_b.mispredict, exp_mp[k]);
            else pass_cnt++;
        end
        @(negedge clk);
        if_b.up_valid = 1'b0;
        #1;
        check_cnt++;
        if (if_b.lk_taken !== 1'b0) $display("FAIL bi_final_taken: got %0b expected 0", if_b.lk_taken);
        else pass_cnt++;
        check_cnt++;
        if (if_b.hit_cnt !== 16'd4) $display("FAIL bi_hit: got %0d expected 4", if_b.hit_cnt);
        else pass_cnt++;
        check_cnt++;
        if (if_b.miss_cnt !== 16'd3) $display("FAIL bi_miss: got %0d expected 3", if_b.miss_cnt);
        else pass_cnt++;
    endtask

    task automatic test_no_valid();
        // entry 5 sits at 00; two stray taken commits would make it 10
        idle_all();
        if_b.lk_pc = 30'd5;
        if_b.up_idx = 6'd5; if_b.up_taken = 1'b1; if_b.up_pred = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check_cnt++;
            if (if_b.mispredict !== 1'b0) $display("FAIL nv_mispredict: got %0b expected 0", if_b.mispredict);
            else pass_cnt++;
        end
        @(negedge clk);
        #1;
        check_cnt++;
        if (if_b.lk_taken !== 1'b0) $display("FAIL nv_taken: got %0b expected 0", if_b.lk_taken);
        else pass_cnt++;
        check_cnt++;
        if (if_b.miss_cnt !== 16'd3) $display("FAIL nv_miss: got %0d expected 3", if_b.miss_cnt);
        else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        idle_all();
        @(negedge clk);
        if_b.lk_pc = 30'd9;
        if_b.up_valid = 1'b1; if_b.up_idx = 6'd9; if_b.up_taken = 1'b1; if_b.up_pred = 1'b0;
        #1;
        check_cnt++;
        if (if_b.lk_taken !== 1'b0) $display("FAIL hz_same_cycle: got %0b expected 0", if_b.lk_taken);
        else pass_cnt++;
        @(negedge clk);
        if_b.up_valid = 1'b0;
        #1;
        check_cnt++;
        if (if_b.lk_taken !== 1'b1) $display("FAIL hz_next_cycle: got %0b expected 1", if_b.lk_taken);
        else pass_cnt++;
        check_cnt++;
        if (if_b.miss_cnt !== 16'd4) $display("FAIL hz_miss: got %0d expected 4", if_b.miss_cnt);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        idle_all();
        @(negedge clk);
        stall = 1'b1;
        if_b.lk_pc = 30'd12;
        if_b.up_valid = 1'b1; if_b.up_idx = 6'd12; if_b.up_taken = 1'b1; if_b.up_pred = 1'b0;
        if_g.lk_pc = 30'd0;
        if_g.up_valid = 1'b1; if_g.up_idx = 6'd0; if_g.up_taken = 1'b1; if_g.up_pred = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            check_cnt++;
            if (if_b.mispredict !== 1'b0) $display("FAIL st_mispredict[%0d]: got %0b expected 0", k, if_b.mispredict);
            else pass_cnt++;
            check_cnt++;
            if (if_b.lk_taken !== 1'b0) $display("FAIL st_taken[%0d]: got %0b expected 0", k, if_b.lk_taken);
            else pass_cnt++;
            check_cnt++;
            if (if_b.miss_cnt !== 16'd4) $display("FAIL st_miss[%0d]: got %0d expected 4", k, if_b.miss_cnt);
            else pass_cnt++;
            check_cnt++;
            if (if_g.lk_idx !== 6'd0) $display("FAIL st_ghr[%0d]: got %0d expected 0", k, if_g.lk_idx);
            else pass_cnt++;
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        check_cnt++;
        if (if_b.mispredict !== 1'b1) $display("FAIL st_release_mispredict: got %0b expected 1", if_b.mispredict);
        else pass_cnt++;
        @(negedge clk);
        if_b.up_valid = 1'b0;
        if_g.up_valid = 1'b0;
        #1;
        check_cnt++;
        if (if_b.lk_taken !== 1'b1) $display("FAIL st_release_taken: got %0b expected 1", if_b.lk_taken);
        else pass_cnt++;
        check_cnt++;
        if (if_b.miss_cnt !== 16'd5) $display("FAIL st_release_miss: got %0d expected 5", if_b.miss_cnt);
        else pass_cnt++;
        check_cnt++;
        if (if_g.lk_idx !== 6'd1) $display("FAIL st_release_ghr: got %0d expected 1", if_g.lk_idx);
        else pass_cnt++;
    endtask

    task automatic test_gshare();
        // history enters this task as 0001
        logic [5:0] exp_idx [4] = '{6'd1, 6'd3, 6'd7, 6'd15};
        idle_all();
        if_g.lk_pc = 30'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if_g.up_valid = 1'b1; if_g.up_idx = 6'd20; if_g.up_taken = 1'b1; if_g.up_pred = 1'b1;
            #1;
            check_cnt++;
            if (if_g.lk_idx !== exp_idx[k]) $display("FAIL gs_hist[%0d]: got %0d expected %0d", k, if_g.lk_idx, exp_idx[k]);
            else pass_cnt++;
        end
        @(negedge clk);
        if_g.up_valid = 1'b0;
        #1;
        check_cnt++;
        if (if_g.lk_idx !== 6'd15) $display("FAIL gs_hist_full: got %0d expected 15", if_g.lk_idx);
        else pass_cnt++;
        if_g.lk_pc = 30'h0000_0003;
        #1;
        check_cnt++;
        if (if_g.lk_idx !== 6'b001100) $display("FAIL gs_idx_pc3: got %0d expected 12", if_g.lk_idx);
        else pass_cnt++;
        @(negedge clk);
        if_g.up_valid = 1'b1; if_g.up_idx = 6'd20; if_g.up_taken = 1'b0; if_g.up_pred = 1'b1;
        @(negedge clk);
        if_g.up_valid = 1'b0;
        #1;
        check_cnt++;
        if (if_g.lk_idx !== 6'd13) $display("FAIL gs_idx_nt: got %0d expected 13", if_g.lk_idx);
        else pass_cnt++;
        if_g.lk_pc = 30'd26;
        #1;
        check_cnt++;
        if (if_g.lk_idx !== 6'd20) $display("FAIL gs_idx_pc26: got %0d expected 20", if_g.lk_idx);
        else pass_cnt++;
        check_cnt++;
        if (if_g.lk_taken !== 1'b1) $display("FAIL gs_taken_20: got %0b expected 1", if_g.lk_taken);
        else pass_cnt++;
    endtask

    task automatic test_stat_sat();
        idle_all();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if_s.up_valid = 1'b1; if_s.up_idx = 6'd1; if_s.up_taken = 1'b0; if_s.up_pred = 1'b0;
            #1;
            if (k == 15) begin
                check_cnt++;
                if (if_s.hit_cnt !== 4'd15) $display("FAIL sat_hit_at15: got %0d expected 15", if_s.hit_cnt);
                else pass_cnt++;
            end
        end
        @(negedge clk);
        if_s.up_valid = 1'b0;
        #1;
        check_cnt++;
        if (if_s.hit_cnt !== 4'd15) $display("FAIL sat_hit_hold: got %0d expected 15", if_s.hit_cnt);
        else pass_cnt++;
        check_cnt++;
        if (if_s.miss_cnt !== 4'd0) $display("FAIL sat_miss: got %0d expected 0", if_s.miss_cnt);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        idle_all();
        @(negedge clk);
        if_b.lk_pc = 30'd12;
        if_b.up_valid = 1'b1; if_b.up_idx = 6'd12; if_b.up_taken = 1'b1; if_b.up_pred = 1'b0;
        if_s.up_valid = 1'b1; if_s.up_idx = 6'd1; if_s.up_taken = 1'b0; if_s.up_pred = 1'b0;
        if_g.lk_pc = 30'd3;
        #1;
        check_cnt++;
        if (if_b.mispredict !== 1'b1) $display("FAIL ar_pre_mispredict: got %0b expected 1", if_b.mispredict);
        else pass_cnt++;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if (if_s.hit_cnt !== 4'd0) $display("FAIL ar_sat_hit: got %0d expected 0", if_s.hit_cnt);
        else pass_cnt++;
        check_cnt++;
        if (if_b.hit_cnt !== 16'd0) $display("FAIL ar_bi_hit: got %0d expected 0", if_b.hit_cnt);
        else pass_cnt++;
        check_cnt++;
        if (if_b.miss_cnt !== 16'd0) $display("FAIL ar_bi_miss: got %0d expected 0", if_b.miss_cnt);
        else pass_cnt++;
        check_cnt++;
        if (if_b.mispredict !== 1'b0) $display("FAIL ar_mispredict: got %0b expected 0", if_b.mispredict);
        else pass_cnt++;
        check_cnt++;
        if (if_b.lk_taken !== 1'b0) $display("FAIL ar_taken_12: got %0b expected 0", if_b.lk_taken);
        else pass_cnt++;
        check_cnt++;
        if (if_g.lk_idx !== 6'd3) $display("FAIL ar_gs_idx: got %0d expected 3", if_g.lk_idx);
        else pass_cnt++;
        @(negedge clk);
        #1;
        check_cnt++;
        if (if_b.miss_cnt !== 16'd0) $display("FAIL ar_hold_miss: got %0d expected 0", if_b.miss_cnt);
        else pass_cnt++;
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int pc = 0; pc < 64; pc++) begin
            if_b.lk_pc = 30'(pc);
            #1;
            check_cnt++;
            if (if_b.lk_taken !== 1'b0) $display("FAIL ar_lk_taken[%0d]: got %0b expected 0", pc, if_b.lk_taken);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_bimodal_sat();
        test_no_valid();
        test_same_cycle();
        test_stall();
        test_gshare();
        test_stat_sat();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/branch_pred_table.md
Name: branch_pred_table

Overview:
- Parametrised successor to the single-counter branch predictor used in the 5-stage MIPS pipeline.
- Holds a table of 2^IDX_W saturating counters. Indexing is either bimodal (PC bits) or gshare (PC XOR global history).
- IF looks up a prediction combinationally. ID writes back the resolved outcome using the index carried down the pipe.
- Per-table hit/miss statistics counters are provided for performance measurement.

Parameters:
- IDX_W, 6, table index width; table depth = 2^IDX_W entries.
- CTR_W, 2, counter width per entry (legal range 1..4).
- HIST_W, 4, global history length (legal range 0..IDX_W; 0 disables history).
- MODE, 0, 0 = bimodal, 1 = gshare.
- STAT_W, 16, width of hit/miss statistics counters.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- stall, input, 1, pipeline stall (hazard, I-cache or D-cache); blocks all state updates.
- lk_pc, input, 30, IF-stage word address (PC[31:2]).
- lk_taken, output, 1, predicted taken for lk_pc.
- lk_idx, output, IDX_W, table index used for the lookup; carried IF->ID by the pipeline.
- up_valid, input, 1, ID stage is resolving a conditional branch this cycle.
- up_idx, input, IDX_W, index returned from lk_idx of that branch.
- up_taken, input, 1, actual branch outcome.
- up_pred, input, 1, prediction that was used for that branch.
- mispredict, output, 1, up_valid & ~stall & (up_pred != up_taken); combinational.
- hit_cnt, output, STAT_W, count of correct predictions.
- miss_cnt, output, STAT_W, count of mispredictions.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - every counter = 2^(CTR_W-1)-1 (weakly not-taken; CTR_W=2 gives 01);
  - ghr = 0; hit_cnt = miss_cnt = 0.
  - Output values in reset: lk_taken=0; lk_idx = lk_pc[IDX_W-1:0]; mispredict=0.
  - Reset mid-update discards the update; no partial writes.
- Lookup (combinational, zero latency):
  - MODE=0: lk_idx = lk_pc[IDX_W-1:0].
  - MODE=1: lk_idx = lk_pc[IDX_W-1:0] XOR {zero-pad, ghr[HIST_W-1:0]}.
  - lk_taken = MSB of table[lk_idx].
- Update commit: when up_valid=1 and stall=0, on the clock edge:
  - up_taken=1: table[up_idx] increments, saturating at 2^CTR_W-1.
  - up_taken=0: table[up_idx] decrements, saturating at 0.
  - ghr <= {ghr[HIST_W-2:0], up_taken} (non-speculative history). Applies when HIST_W>0 in both modes; ghr has no effect on indexing in MODE=0.
  - If up_pred==up_taken, hit_cnt increments; otherwise miss_cnt increments. Both saturate at all-ones; no wrap.
- Gating:
  - stall=1: no counter, ghr or statistics change; mispredict forced 0.
  - Each resolved branch commits exactly once, on the first cycle it is presented with stall=0.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value (no bypass). The new value is visible from the next cycle.
- up_valid=0: no state change regardless of other update inputs.
- Table storage is flops; no SRAM. Roughly 2^IDX_W*CTR_W bits.

Test Plan:
- Reset then idle -> lk_taken=0 for all 64 indices; hit_cnt=miss_cnt=0; mispredict=0.
- MODE=0, entry 5: up_idx=5, up_taken=1 three times, stall=0 -> counter goes 01->10->11->11 (saturates). lk_pc=5 gives lk_taken=1 after the first update. Then four not-taken updates -> 10,01,00,00; lk_taken=0.
- Same-cycle hazard: lk_pc=5 with counter=01 while updating idx 5 taken -> lk_taken=0 that cycle, 1 the next cycle.
- Stall gating: up_valid=1, up_taken=1, up_pred=0, stall=1 for 3 cycles -> no table/ghr/stat change, mispredict=0. Then stall=0 for 1 cycle -> mispredict=1 that cycle; miss_cnt=1; counter 01->10.
- MODE=1, HIST_W=4: four taken updates -> ghr=1111. lk_pc=0x00000003 then gives lk_idx=6'b001100.
- Saturation with STAT_W=4: 20 correct updates -> hit_cnt holds at 15. Assert rst_n low mid-sequence -> all counters and statistics clear immediately, asynchronously.
